uart_rx_ctrl: RTL and testbench

Receive-side frame controller for the UART RX path. Oversamples `RX_IN` and walks each frame through start, data, parity and stop bits. Deserialises the data into `P_DATA` and drives `sampled_bit`/`par_chk_en` to the downstream parity checker. Consumes that checker's registered `par_err` to qualify `data_valid`.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx_ctrl.sv | 85 ++++++++
 tb/tb_uart_rx_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART RX state encoding, legal prescale ratios and vote helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int PRESCALE_8 = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: bit-period edge counter and mid-bit sampler; UART_RX_MAJORITY_EN selects 2-of-3 vote
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  bit_end,
  output logic                  sample_vld,
  output logic                  sampled_bit
);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  logic [PRESCALE_W-1:0] half;
  logic s_mid, vote;
  assign half = prescale >> 1;
  assign bit_end = edge_cnt == prescale - ONE;
`ifdef UART_RX_MAJORITY_EN
  logic s_early;
  always_ff @(posedge clk) begin
    if (rst) s_early <= 1'b0;
    else if (edge_cnt == half - ONE) s_early <= rx_in;
  end
  assign vote = maj3(s_early, s_mid, rx_in);
`else
  assign vote = s_mid;
`endif
  // the third vote comes straight off the line at H+1, so the result lands at H+2
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      s_mid <= 1'b0;
      sample_vld <= 1'b0;
      sampled_bit <= 1'b0;
    end else begin
      edge_cnt <= en ? (bit_end ? '0 : edge_cnt + ONE) : '0;
      if (edge_cnt == half) s_mid <= rx_in;
      sample_vld <= en && edge_cnt == half + ONE;
      if (en && edge_cnt == half + ONE) sampled_bit <= vote;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame FSM and deserialiser; sampling mode set by UART_RX_MAJORITY_EN
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  par_err,
  output logic                  sampled_bit,
  output logic                  sample_vld,
  output logic                  par_chk_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  strt_err,
  output logic                  stp_err
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH);
  rx_state_t state, next;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic bit_end, start, en, par_en_q, par_chk_q, perr_q;
  assign start = state == IDLE && !RX_IN && edge_cnt == '0;
  assign en = state != IDLE || start;
  assign par_chk_en = sample_vld && state == PARITY;
  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk(CLK),
    .rst(RST),
    .en(en),
    .rx_in(RX_IN),
    .prescale(Prescale),
    .edge_cnt(edge_cnt),
    .bit_end(bit_end),
    .sample_vld(sample_vld),
    .sampled_bit(sampled_bit)
  );
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? START : IDLE;
      START:   if (bit_end) next = sampled_bit ? IDLE : DATA;
      DATA:    if (bit_end && bit_cnt == LAST) next = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) next = STOP;
      STOP:    if (bit_end) next = IDLE;
      default: next = IDLE;
    endcase
  end
  // par_err from the checker trails par_chk_en by one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA <= '0;
      bit_cnt <= '0;
      par_en_q <= 1'b0;
      par_chk_q <= 1'b0;
      perr_q <= 1'b0;
      data_valid <= 1'b0;
      strt_err <= 1'b0;
      stp_err <= 1'b0;
    end else begin
      par_chk_q <= par_chk_en;
      strt_err <= state == START && bit_end && sampled_bit;
      stp_err <= state == STOP && bit_end && !sampled_bit;
      data_valid <= state == STOP && bit_end && sampled_bit && !perr_q;
      if (state == IDLE) begin
        bit_cnt <= '0;
        perr_q <= 1'b0;
        par_en_q <= PAR_EN;
      end
      if (par_chk_q) perr_q <= par_err;
      if (state == DATA && sample_vld) begin
        P_DATA <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random frame checks of uart_rx_ctrl against a frame-level model
module tb_uart_rx_ctrl;
  import uart_pkg::*;
  logic CLK = 1'b0;
  logic RST, RX_IN, PAR_EN, par_err;
  logic [5:0] Prescale;
  logic sampled_bit, sample_vld, par_chk_en, data_valid, strt_err, stp_err;
  logic [7:0] P_DATA;
  int checks = 0, fails = 0;
  int n_dv = 0, n_se = 0, n_st = 0, n_pc = 0, n_wide = 0;
  int b_dv, b_se, b_st, b_pc;
  logic [7:0] dv_q[$];
  logic [7:0] pd_pc;
  logic sb_pc;
  logic [4:0] prev = '0;

  always #5 CLK = ~CLK;

  uart_rx_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .par_err(par_err), .sampled_bit(sampled_bit), .sample_vld(sample_vld),
    .par_chk_en(par_chk_en), .P_DATA(P_DATA), .data_valid(data_valid),
    .strt_err(strt_err), .stp_err(stp_err)
  );

  // downstream even-parity checker: registered result one cycle after par_chk_en
  always @(posedge CLK) begin
    if (RST) par_err <= 1'b0;
    else if (par_chk_en) par_err <= (^P_DATA) ^ sampled_bit;
  end

  always @(negedge CLK) begin
    if (data_valid) begin n_dv++; dv_q.push_back(P_DATA); end
    if (stp_err) n_se++;
    if (strt_err) n_st++;
    if (par_chk_en) begin n_pc++; pd_pc = P_DATA; sb_pc = sampled_bit; end
    if (|(prev & {data_valid, stp_err, strt_err, par_chk_en, sample_vld})) n_wide++;
    prev = {data_valid, stp_err, strt_err, par_chk_en, sample_vld};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic v, input int g);
    int p = int'(Prescale);
    if (g < 0) drive(v, p);
    else begin
      drive(v, g);
      drive(!v, 1);
      drive(v, p - g - 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic st, input int g);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], g);
    if (PAR_EN) send_bit(pb, -1);
    send_bit(st, -1);
  endtask

  task automatic snap();
    b_dv = n_dv; b_se = n_se; b_st = n_st; b_pc = n_pc;
  endtask

  // frame-level expectation: one frame then a short idle gap
  task automatic frame_check(input string tag, input logic [7:0] d, input logic pb, input logic st);
    logic exp_dv;
    exp_dv = st && (!PAR_EN || pb == ^d);
    snap();
    send_frame(d, pb, st, -1);
    drive(1'b1, 3);
    check({tag, " data_valid"}, n_dv - b_dv, exp_dv ? 1 : 0);
    check({tag, " stp_err"}, n_se - b_se, st ? 0 : 1);
    check({tag, " par_chk_en"}, n_pc - b_pc, PAR_EN ? 1 : 0);
    check({tag, " P_DATA"}, 32'(P_DATA), 32'(d));
    if (PAR_EN) check({tag, " parity sample"}, 32'(sb_pc), 32'(pb));
    if (exp_dv) check({tag, " P_DATA at data_valid"}, 32'(dv_q[dv_q.size() - 1]), 32'(d));
  endtask

  initial begin
    logic [7:0] d;
    logic pb, st;
    int sel, g;
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b1; Prescale = 6'(PRESCALE_8);
    repeat (3) @(posedge CLK);
    #1;
    check("reset outputs", 32'({sampled_bit, sample_vld, par_chk_en, P_DATA, data_valid, strt_err, stp_err}), 0);
    RST = 1'b0;
    drive(1'b1, 4);

    frame_check("p8 good parity", 8'hA5, 1'b0, 1'b1);
    check("p8 P_DATA at par_chk_en", 32'(pd_pc), 32'hA5);
    frame_check("p8 bad parity", 8'hA5, 1'b1, 1'b1);

    PAR_EN = 1'b0; Prescale = 6'(PRESCALE_16);
    drive(1'b1, 2);
    frame_check("p16 stop error", 8'h3C, 1'b0, 1'b0);

    snap();
    drive(1'b0, 3);
    drive(1'b1, 24);
    check("start glitch strt_err", n_st - b_st, 1);
    check("start glitch data_valid", n_dv - b_dv, 0);
    check("start glitch P_DATA", 32'(P_DATA), 32'h3C);

    PAR_EN = 1'b1; Prescale = 6'(PRESCALE_32);
    drive(1'b1, 2);
    snap();
    send_frame(8'h01, 1'b1, 1'b1, -1);
    send_frame(8'hFE, 1'b1, 1'b1, -1);
    drive(1'b1, 3);
    check("back-to-back count", n_dv - b_dv, 2);
    check("back-to-back first", 32'(dv_q[dv_q.size() - 2]), 32'h01);
    check("back-to-back second", 32'(dv_q[dv_q.size() - 1]), 32'hFE);

    PAR_EN = 1'b0; Prescale = 6'(PRESCALE_8);
    drive(1'b1, 2);
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    drive(1'b1, 5);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("mid-data reset outputs", 32'({sampled_bit, sample_vld, par_chk_en, P_DATA, data_valid, strt_err, stp_err}), 0);
    RST = 1'b0;
    drive(1'b1, 20);
    frame_check("after reset", 8'h55, 1'b0, 1'b1);

    Prescale = 6'(PRESCALE_16);
    drive(1'b1, 2);
`ifdef UART_RX_MAJORITY_EN
    g = PRESCALE_16 / 2;
`else
    g = PRESCALE_16 / 2 - 1;
`endif
    snap();
    send_frame(8'h96, 1'b0, 1'b1, g);
    drive(1'b1, 3);
    check("glitched data_valid", n_dv - b_dv, 1);
    check("glitched P_DATA", 32'(P_DATA), 32'h96);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 2);
      Prescale = 6'(sel == 0 ? PRESCALE_8 : sel == 1 ? PRESCALE_16 : PRESCALE_32);
      PAR_EN = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      st = $urandom_range(0, 3) != 0;
      drive(1'b1, 1 + $urandom_range(0, 3));
      frame_check($sformatf("random %0d", i), d, pb, st);
    end

    check("total strt_err", n_st, 1);
    check("strobes one cycle wide", n_wide, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
